// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and byte-lane geometry of the 32-bit instruction word.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte packer: the first pushed byte lands in bits [7:0].
// full flags the push that completes the current word.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                clk,
  input  logic                areset,
  input  logic                clear,
  input  logic                push,
  input  logic [BYTE_W-1:0]   byte_in,
  output logic [WORD_W-1:0]   word,
  output logic                full
);

  logic [LANE_W-1:0] lane;

  // The push into the last lane completes a word this cycle.
  assign full = push && (lane == LANE_W'(BYTES_PER_WORD - 1));

  // Lane counter and assembly register; clear wins over push so a new
  // load never inherits a stale partial word.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
    end else if (push) begin
      word[{lane, 3'b000} +: BYTE_W] <= byte_in;
      lane                           <= lane + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into 32-bit words, writes them to
// consecutive instruction-memory addresses and holds the core until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len_words,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // Largest legal length is the full memory depth; counters are one bit
  // wider than the address so this value is representable.
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state;
  state_t              state_nx;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [ADDR_WIDTH:0] word_cnt_inc;
  logic                len_ok;
  logic                start_seen;
  logic                last_word;
  logic                push;
  logic                full;
  logic                pack_clear;
  logic [WORD_W-1:0]   packed_word;

  assign len_ok       = (len_words != '0) && (len_words <= MAX_LEN);
  assign start_seen   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign push         = (state == ST_LOAD) && byte_valid;
  assign word_cnt_inc = word_cnt + 1'b1;
  assign last_word    = (word_cnt_inc == len_q);

  imem_byte_packer u_packer (
    .clk     (clk),
    .areset  (areset),
    .clear   (pack_clear),
    .push    (push),
    .byte_in (byte_data),
    .word    (packed_word),
    .full    (full)
  );

  // State register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; the packer is cleared on a legal start and after
  // every word write so each word starts at lane 0.
  always_comb begin
    state_nx   = state;
    pack_clear = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (len_ok) begin
            state_nx   = ST_LOAD;
            pack_clear = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_LOAD: begin
        if (full) begin
          state_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        pack_clear = 1'b1;
        state_nx   = last_word ? ST_DONE : ST_LOAD;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Length latch, word counter and error flag; start is only honoured
  // in IDLE/DONE, so a pulse mid-load leaves these untouched.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      len_q    <= '0;
      word_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (start_seen) begin
        if (len_ok) begin
          len_q    <= len_words;
          word_cnt <= '0;
          err      <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else if (state == ST_WRITE) begin
        word_cnt <= word_cnt_inc;
      end
    end
  end

  // Outputs decoded from registered state and counters only.
  assign byte_ready = (state == ST_LOAD);
  assign mem_we     = (state == ST_WRITE);
  assign mem_addr   = word_cnt[ADDR_WIDTH-1:0];
  assign mem_wdata  = DATA_WIDTH'(packed_word);
  assign busy       = (state == ST_LOAD) || (state == ST_WRITE);
  assign done       = (state == ST_DONE);
  assign core_hold  = (state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load cases plus hand-written
// sequences for full depth, reset mid-load and start during LOAD/DONE.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          areset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   len_words = '0;
  logic [7:0]    byte_data = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];

  typedef struct {
    logic [AW:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .areset     (areset),
    .start      (start),
    .len_words  (len_words),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Record every memory write pulse.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset     = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start(input logic [AW:0] len);
    start     = 1'b1;
    len_words = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte and return at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n          = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_ready_timeout: got %b, expected 1", byte_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_lane);
    for (int l = 0; l < 4; l++) begin
      send_byte(w[8*l +: 8]);
      if (l == gap_lane) begin
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", 32'(done), 32'd1);
  endtask

  initial begin
    vecs[0] = '{len: 9'd2, w0: 32'h0000_0013, w1: 32'h00A0_0293, gap: -1, exp_err: 1'b0};
    vecs[1] = '{len: 9'd2, w0: 32'h0000_0013, w1: 32'h00A0_0293, gap: 1,  exp_err: 1'b0};
    vecs[2] = '{len: 9'd0, w0: 32'h0,         w1: 32'h0,         gap: -1, exp_err: 1'b1};
    vecs[3] = '{len: 9'd257, w0: 32'h0,       w1: 32'h0,         gap: -1, exp_err: 1'b1};
    vecs[4] = '{len: 9'd1, w0: 32'hDEAD_BEEF, w1: 32'h0,         gap: 0,  exp_err: 1'b0};

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  mem_wdata,       32'd0);
    check("rst_core_hold",  32'(core_hold),  32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_err",        32'(err),        32'd0);

    // Table-driven load cases.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      pulse_start(vecs[i].len);
      if (!vecs[i].exp_err) begin
        check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
        send_word(vecs[i].w0, vecs[i].gap);
        check($sformatf("v%0d_we_latency", i), 32'(mem_we), 32'd1);
        check($sformatf("v%0d_addr_latency", i), 32'(mem_addr), 32'd0);
        if (vecs[i].len > 9'd1) send_word(vecs[i].w1, -1);
        byte_valid = 1'b0;
        wait_done(50);
        check($sformatf("v%0d_wr_count", i), 32'(wr_addr_q.size()), 32'(vecs[i].len));
        for (int j = 0; j < wr_addr_q.size(); j++) begin
          check($sformatf("v%0d_addr%0d", i, j), 32'(wr_addr_q[j]), j);
          check($sformatf("v%0d_data%0d", i, j), wr_data_q[j], (j == 0) ? vecs[i].w0 : vecs[i].w1);
        end
        check($sformatf("v%0d_core_hold", i), 32'(core_hold), 32'd0);
        check($sformatf("v%0d_err", i), 32'(err), 32'd0);
        check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
      end else begin
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_err", i), 32'(err), 32'd1);
        check($sformatf("v%0d_wr_count", i), 32'(wr_addr_q.size()), 32'd0);
        check($sformatf("v%0d_core_hold", i), 32'(core_hold), 32'd1);
        check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        check($sformatf("v%0d_done", i), 32'(done), 32'd0);
      end
    end

    // Full-depth load: 256 incrementing words.
    do_reset();
    pulse_start(9'd256);
    for (int w = 0; w < 256; w++) send_word(32'(w) * 32'h0001_0001 + 32'h0300_0000, -1);
    byte_valid = 1'b0;
    wait_done(100);
    check("full_wr_count", 32'(wr_addr_q.size()), 32'd256);
    for (int j = 0; j < wr_addr_q.size(); j++) begin
      check($sformatf("full_addr%0d", j), 32'(wr_addr_q[j]), j);
      check($sformatf("full_data%0d", j), wr_data_q[j], 32'(j) * 32'h0001_0001 + 32'h0300_0000);
    end
    if (wr_addr_q.size() > 0) check("full_last_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 32'hFF);
    check("full_core_hold", 32'(core_hold), 32'd0);

    // Reset after 6 bytes of a 2-word load.
    do_reset();
    pulse_start(9'd2);
    send_word(32'h4433_2211, -1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_valid = 1'b0;
    areset     = 1'b0;
    #1;
    check("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_mem_we",     32'(mem_we),     32'd0);
    check("mid_rst_mem_addr",   32'(mem_addr),   32'd0);
    check("mid_rst_mem_wdata",  mem_wdata,       32'd0);
    check("mid_rst_core_hold",  32'(core_hold),  32'd1);
    check("mid_rst_busy",       32'(busy),       32'd0);
    check("mid_rst_done",       32'(done),       32'd0);
    check("mid_rst_wr_count",   32'(wr_addr_q.size()), 32'd1);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(9'd1);
    send_word(32'hCAFE_F00D, -1);
    byte_valid = 1'b0;
    wait_done(20);
    check("post_rst_wr_count", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      check("post_rst_addr", 32'(wr_addr_q[0]), 32'd0);
      check("post_rst_data", wr_data_q[0], 32'hCAFE_F00D);
    end

    // start pulsed during LOAD is ignored; start from DONE restarts.
    do_reset();
    pulse_start(9'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    byte_valid = 1'b0;
    pulse_start(9'd5);
    check("ign_busy",       32'(busy),       32'd1);
    check("ign_byte_ready", 32'(byte_ready), 32'd1);
    check("ign_err",        32'(err),        32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h00A0_0293, -1);
    byte_valid = 1'b0;
    wait_done(20);
    check("ign_wr_count", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("ign_data0", wr_data_q[0], 32'h0000_0013);
      check("ign_data1", wr_data_q[1], 32'h00A0_0293);
      check("ign_addr1", 32'(wr_addr_q[1]), 32'd1);
    end
    check("done_core_hold", 32'(core_hold), 32'd0);
    pulse_start(9'd1);
    check("restart_core_hold", 32'(core_hold), 32'd1);
    check("restart_done",      32'(done),      32'd0);
    check("restart_busy",      32'(busy),      32'd1);
    send_word(32'h1234_5678, -1);
    byte_valid = 1'b0;
    wait_done(20);
    check("restart_wr_count", 32'(wr_addr_q.size()), 32'd3);
    if (wr_addr_q.size() == 3) begin
      check("restart_addr", 32'(wr_addr_q[2]), 32'd0);
      check("restart_data", wr_data_q[2], 32'h1234_5678);
    end
    pulse_start(9'd0);
    check("done_bad_err",       32'(err),       32'd1);
    check("done_bad_done",      32'(done),      32'd0);
    check("done_bad_core_hold", 32'(core_hold), 32'd1);
    check("done_bad_busy",      32'(busy),      32'd0);
    pulse_start(9'd1);
    check("err_clear", 32'(err), 32'd0);
    send_word(32'h0BAD_F00D, -1);
    byte_valid = 1'b0;
    wait_done(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that writes the instruction memory the core fetches from. It accepts a little-endian byte stream on a valid/ready handshake, packs each four bytes into a 32-bit word, and issues one single-cycle write per word at consecutive word addresses. While a load is pending or in progress, it holds the core via core_hold. When the requested word count has been written, it releases the core.

Parameters:
ADDR_WIDTH, 8, word-address width of instruction memory; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, memory word width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  system clock, rising edge
areset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a load; sampled in IDLE or DONE only
len_words  input  ADDR_WIDTH+1  number of words to load; sampled on accepted start
byte_data  input  8  stream byte
byte_valid  input  1  byte_data is valid
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction-memory write enable, one-cycle pulse per word
mem_addr  output  ADDR_WIDTH  word address of the write
mem_wdata  output  32  packed word
core_hold  output  1  keeps the core in reset/stalled while 1
busy  output  1  load in progress (LOAD or WRITE)
done  output  1  last load completed successfully; cleared on next start
err  output  1  last start had an illegal length; cleared on next start

Behaviour:
- Reset (areset=0, asynchronous):
  - state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_hold=1, busy=0, done=0, err=0; lane counter=0, word counter=0.
  - Any partial word is discarded.
- Byte handshake: a byte transfers on a rising edge when byte_valid=1 and byte_ready=1. byte_ready=1 only in LOAD.
- IDLE (core_hold=1):
  - start with 1 <= len_words <= 2**ADDR_WIDTH: latch len, clear done/err, word=0, lane=0, go to LOAD.
  - start with len_words=0 or > 2**ADDR_WIDTH: err=1, stay in IDLE, no write.
- LOAD:
  - Each accepted byte goes to lane = lane counter: bits [8*lane+7:8*lane]; the first byte lands in [7:0] (little-endian).
  - Lane increments; on acceptance of lane 3, go to WRITE.
  - start is ignored.
- WRITE (byte_ready=0):
  - For exactly one cycle: mem_we=1, mem_addr=word counter, mem_wdata=packed word.
  - Next edge: word counter+1, lane=0.
  - If word counter+1 == len, go to DONE; otherwise return to LOAD.
  - Latency: mem_we asserts in the cycle immediately after the 4th byte is accepted. Peak throughput is one word per 5 cycles.
- DONE:
  - done=1, core_hold=0, byte_ready=0.
  - start re-enters the same checks as IDLE. A legal start raises core_hold to 1 in the cycle after start.
  - An illegal start from DONE sets err=1, clears done, raises core_hold=1 and goes to IDLE.
- Boundaries:
  - len_words = 2**ADDR_WIDTH: final mem_addr = 2**ADDR_WIDTH-1; the word counter must not wrap before the comparison (it is ADDR_WIDTH+1 bits wide).
  - byte_valid held high across a WRITE cycle: no byte is taken during WRITE; the byte is taken in the following LOAD cycle.
  - byte_valid gaps: lane and data hold their values.
  - Reset mid-load: immediate return to IDLE; already-written words are not undone.
- busy = (state==LOAD or state==WRITE).
- All outputs are registered, or decoded from the registered state only.

Decomposition:
- Shared package: state encoding (IDLE, LOAD, WRITE, DONE), BYTES_PER_WORD=4, LANE_W=2.
- One natural sub-module: imem_byte_packer. It holds the lane counter and the 32-bit assembly register, with inputs clear and push and outputs word and full.
- The FSM, word counter and length check stay in imem_loader.

Test Plan:
1. Reset, then start with len_words=2 and bytes 13,00,00,00,93,02,A0,00 streamed back-to-back. Required: mem_we pulses twice, addr0=0x00000013 and addr1=0x00A00293; done=1 and core_hold=0 afterwards.
2. Same load with byte_valid dropped for 3 cycles between bytes 2 and 3. Required: identical writes, one mem_we per word, no duplicate or lost bytes.
3. start with len_words=0, and separately with len_words=257 (ADDR_WIDTH=8). Required: err=1, no mem_we, core_hold stays 1.
4. Full-depth load with len_words=256 and incrementing words. Required: last write at mem_addr=0xFF, then DONE with exactly 256 write pulses.
5. areset asserted after 6 bytes of a 2-word load. Required: outputs return to reset values immediately. A fresh load of 1 word then writes addr0 using only the new bytes.
6. start pulsed during LOAD. Required: ignored, counters unchanged. After DONE, a new legal start raises core_hold=1 and clears done.
